pulp_clock_divider_cfg: RTL

// - Programmable integer clock divider that generates a derived clock from clk_i for peripheral/SoC clock trees.
// - Complements the clock inverter, which only inverts a clock: this block creates a clock, registered and glitch-free.
// - New ratios are accepted over a valid/ready handshake and applied only at a period boundary.

---
 rtl/pulp_clk_div_pkg.sv | 18 +
 rtl/pulp_clk_div_counter.sv | 37 +++
 rtl/pulp_clock_divider_cfg.sv | 101 ++++++++++
 3 files changed

// File: rtl/pulp_clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package pulp_clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_e;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned clamp_div(
    input int unsigned d
  );
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/pulp_clk_div_counter.sv
// Period counter: cnt runs 0..D-1, flags the last cycle and
// predicts whether the next count lands in the high phase.
module pulp_clk_div_counter #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [DIV_W-1:0] cnt_o,
  output logic             last_o,
  output logic             hi_next_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W:0]   half;
  logic [DIV_W:0]   nxt;

  // Extra bit keeps (D+1)>>1 exact at the top of the range.
  assign half = ({1'b0, div_i} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  assign nxt  = {1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1};

  assign last_o    = (cnt_q == (div_i - 1'b1));
  assign hi_next_o = last_o || (nxt < half);
  assign cnt_d     = (!run_i || last_o) ? '0 : nxt[DIV_W-1:0];
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulp_clock_divider_cfg.sv
// Glitch-free programmable clock divider with handshaked ratio updates.
// PULP_CLK_DIV_TESTMODE_EN adds test_mode_i to bypass clk_o to clk_i.
module pulp_clock_divider_cfg
  import pulp_clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic             busy_o,
`ifdef PULP_CLK_DIV_TESTMODE_EN
  input  logic             test_mode_i,
`endif
  output logic             clk_o
);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_q;
  logic             clk_q;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] cnt;
  logic             last;
  logic             hi_next;
  logic             accept;

  assign eff_div = DIV_W'(clamp_div(32'(div_q)));
  assign accept  = cfg_valid_i && !pend_q;

  pulp_clk_div_counter #(
    .DIV_W(DIV_W)
  ) u_cnt (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .run_i    (state_q != IDLE),
    .div_i    (eff_div),
    .cnt_o    (cnt),
    .last_o   (last),
    .hi_next_o(hi_next)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      div_q      <= DIV_W'(DIV_RST);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
    end else begin
      if (accept) begin
        pend_div_q <= DIV_W'(clamp_div(32'(cfg_div_i)));
        pend_q     <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            div_q  <= pend_div_q;
            pend_q <= 1'b0;
          end
          state_q <= en_i ? RUN : IDLE;
          clk_q   <= en_i;
        end
        RUN, STOP: begin
          // en_i only matters on the boundary; mid-period it just
          // toggles between RUN and STOP.
          if (last) begin
            if (pend_q) begin
              div_q  <= pend_div_q;
              pend_q <= 1'b0;
            end
            state_q <= en_i ? RUN : IDLE;
            clk_q   <= en_i;
          end else begin
            state_q <= en_i ? RUN : STOP;
            clk_q   <= hi_next;
          end
        end
        default: begin
          state_q <= IDLE;
          clk_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready_o = !pend_q;
  assign busy_o      = (state_q != IDLE);

`ifdef PULP_CLK_DIV_TESTMODE_EN
  assign clk_o = test_mode_i ? clk_i : clk_q;
`else
  assign clk_o = clk_q;
`endif

endmodule
